// File: rtl/hcsr04_distance_meter_pkg.sv
// Shared definitions for the HC-SR04 distance meter: FSM state codes,
// default timing for a 50 MHz clock and a small sizing helper.
package hcsr04_distance_meter_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        ENVIA_TRIG  = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARREDONDA   = 4'd5,
        ARMAZENA    = 4'd6,
        FINAL       = 4'd7,
        TIMEOUT     = 4'd8
    } estado_t;

    localparam int DEF_TRIG_CYCLES      = 500;
    localparam int DEF_CM_CYCLES        = 2941;
    localparam int DEF_ECHO_WAIT_CYCLES = 1_500_000;
    localparam int DEF_ECHO_MAX_CYCLES  = 1_250_000;

    localparam logic [11:0] BCD_MAX = 12'h999;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/hcsr04_distance_meter_contador_bcd_3dig.sv
// Three-digit BCD up-counter with synchronous clear and enable.
// It holds at 999 instead of wrapping, so long echoes read as full scale.
module contador_bcd_3dig
    import hcsr04_distance_meter_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [11:0] o_bcd
);

    logic [11:0] r_bcd;
    logic [11:0] w_next;

    always_comb begin
        w_next = r_bcd;
        if (i_clr) begin
            w_next = 12'h000;
        end else if (i_en && (r_bcd != BCD_MAX)) begin
            if (r_bcd[3:0] != 4'd9) begin
                w_next[3:0] = r_bcd[3:0] + 4'd1;
            end else begin
                w_next[3:0] = 4'd0;
                if (r_bcd[7:4] != 4'd9) begin
                    w_next[7:4] = r_bcd[7:4] + 4'd1;
                end else begin
                    // 999 is excluded above, so hundreds cannot overflow here
                    w_next[7:4]  = 4'd0;
                    w_next[11:8] = r_bcd[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bcd <= 12'h000;
        end else begin
            r_bcd <= w_next;
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/hcsr04_distance_meter.sv
// HC-SR04 driver: fires a trigger pulse, times the echo in whole-cm steps,
// rounds the remainder to the nearest cm and reports BCD centimetres.
module hcsr04_distance_meter
    import hcsr04_distance_meter_pkg::*;
#(
    parameter int TRIG_CYCLES      = DEF_TRIG_CYCLES,
    parameter int CM_CYCLES        = DEF_CM_CYCLES,
    parameter int ECHO_WAIT_CYCLES = DEF_ECHO_WAIT_CYCLES,
    parameter int ECHO_MAX_CYCLES  = DEF_ECHO_MAX_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int CNT_W  = $clog2(max_of3(TRIG_CYCLES, ECHO_WAIT_CYCLES, ECHO_MAX_CYCLES) + 1);
    localparam int TICK_W = (CM_CYCLES > 2) ? $clog2(CM_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_LAST  = CNT_W'(ECHO_MAX_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CM_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CM_CYCLES / 2);

    estado_t            r_estado;
    estado_t            w_prox;
    logic               r_echo_meta;
    logic               r_echo_sync;
    logic [CNT_W-1:0]   r_cnt;
    logic [TICK_W-1:0]  r_tick;
    logic [11:0]        r_medida;
    logic [11:0]        w_acc;
    logic               w_acc_clr;
    logic               w_acc_en;
    logic               w_trigger;
    logic               w_pronto;
    logic               w_erro;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_echo_meta <= 1'b0;
            r_echo_sync <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_sync <= r_echo_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox    = r_estado;
        w_trigger = 1'b0;
        w_pronto  = 1'b0;
        w_erro    = 1'b0;
        case (r_estado)
            INICIAL:     if (medir) w_prox = PREPARA;
            PREPARA:     w_prox = ENVIA_TRIG;
            ENVIA_TRIG: begin
                w_trigger = 1'b1;
                if (r_cnt == TRIG_LAST) w_prox = ESPERA_ECHO;
            end
            ESPERA_ECHO: begin
                if (r_echo_sync)                w_prox = MEDE;
                else if (r_cnt == WAIT_LAST)    w_prox = TIMEOUT;
            end
            MEDE: begin
                if (!r_echo_sync)               w_prox = ARREDONDA;
                else if (r_cnt == MAX_LAST)     w_prox = TIMEOUT;
            end
            ARREDONDA:   w_prox = ARMAZENA;
            ARMAZENA:    w_prox = FINAL;
            FINAL: begin
                w_pronto = 1'b1;
                w_prox   = INICIAL;
            end
            TIMEOUT: begin
                w_erro = 1'b1;
                w_prox = INICIAL;
            end
            default:     w_prox = INICIAL;
        endcase
    end

    // r_cnt is the shared trigger / wait / echo-length counter; r_tick is the
    // cm prescaler. The cycle that first sees echo high is counted on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= '0;
        end else begin
            case (r_estado)
                PREPARA: begin
                    r_cnt  <= '0;
                    r_tick <= '0;
                end
                ENVIA_TRIG: begin
                    r_cnt <= (r_cnt == TRIG_LAST) ? '0 : r_cnt + CNT_W'(1);
                end
                ESPERA_ECHO: begin
                    if (r_echo_sync) begin
                        r_cnt  <= CNT_W'(1);
                        r_tick <= TICK_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                MEDE: begin
                    if (r_echo_sync) begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TICK_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_acc_clr = (r_estado == PREPARA);
    assign w_acc_en  = ((r_estado == MEDE) && r_echo_sync && (r_tick == TICK_LAST)) ||
                       ((r_estado == ARREDONDA) && (r_tick >= TICK_HALF));

    contador_bcd_3dig u_acc (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_clr     (w_acc_clr),
        .i_en      (w_acc_en),
        .o_bcd     (w_acc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_medida <= 12'h000;
        end else if (r_estado == ARMAZENA) begin
            r_medida <= w_acc;
        end
    end

    assign trigger   = w_trigger;
    assign pronto    = w_pronto;
    assign erro      = w_erro;
    assign medida    = r_medida;
    assign db_estado = r_estado;

endmodule
